btb_branch_predictor: RTL and testbench
=======================================

Name: btb_branch_predictor

Overview:
- Parametrised fetch-stage branch predictor: direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Fetch consults it each cycle to choose the next PC speculatively, replacing the fixed PC+4 policy.
- The resolving stage reports branch/jump outcomes back; the block updates the table and flags mispredictions with a recovery PC for pipeline flush.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, at least 2; IDX_W = log2(ENTRIES).
ADDR_W, 32, PC/target width in bits; word-aligned, bits [1:0] ignored.
CTR_INIT, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
CLK  input  1  system clock, rising edge.
nRST  input  1  reset; one clock; reset is asynchronous and active-high.
lookup_pc  input  ADDR_W  PC currently being fetched.
predict_taken  output  1  lookup hit with counter bit[1] set.
predict_target  output  ADDR_W  predicted next PC.
update_en  input  1  one-cycle pulse when a control-flow instruction resolves.
update_pc  input  ADDR_W  PC of the resolving instruction.
update_taken  input  1  actual outcome.
update_target  input  ADDR_W  actual taken target.
update_pred_taken  input  1  prediction carried down the pipe with this instruction.
update_pred_target  input  ADDR_W  predicted target carried down the pipe.
flush_all  input  1  synchronously invalidate every entry.
mispredict  output  1  resolving instruction was mispredicted.
redirect_pc  output  ADDR_W  correct next PC when mispredict=1.

Behaviour:
- Entry fields: valid, tag = pc[ADDR_W-1:IDX_W+2], target[ADDR_W-1:2], ctr[1:0].
- Index = pc[IDX_W+1:2].
- Lookup (combinational, zero latency):
  - hit = valid[idx] & tag match.
  - predict_taken = hit & ctr[1].
  - predict_target = predict_taken ? {target,2'b00} : lookup_pc+4, modulo 2^ADDR_W (0xFFFFFFFC+4 wraps to 0).
- Lookup reads the pre-edge table state; no same-cycle bypass from update.
- Update at the rising edge when update_en=1 and flush_all=0:
  - Hit on update_pc, taken: ctr saturating increment (max 11); target overwritten with update_target.
  - Hit on update_pc, not taken: ctr saturating decrement (min 00); target unchanged.
  - Miss, taken: allocate/overwrite the indexed entry. valid=1, new tag, target=update_target, ctr=2'b10.
  - Miss, not taken: no change.
- Mispredict (combinational):
  - mispredict = update_en & ((update_taken != update_pred_taken) | (update_taken & update_pred_taken & update_target != update_pred_target)).
  - redirect_pc = update_taken ? update_target : update_pc+4.
  - When update_en=0: mispredict=0, redirect_pc=0.
- flush_all: all valid bits clear at the next edge; counters and targets are kept. flush_all and update_en in the same cycle: flush wins, the update is dropped.
- Lookup and update on the same index in the same cycle: lookup returns old contents; the new contents are visible the next cycle.
- Reset (asynchronous, any time, including mid-update):
  - All valid=0, ctr=CTR_INIT, targets=0.
  - Outputs settle immediately: predict_taken=0, predict_target=lookup_pc+4.
  - mispredict and redirect_pc follow the inputs combinationally.
- No internal FSM beyond the per-entry counter FSM: states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds outputs stat_lookups, stat_hits, stat_mispredicts (32 bits each, reset 0).
  - stat_lookups increments every cycle nRST=0.
  - stat_hits increments on lookup hit.
  - stat_mispredicts increments when mispredict=1.
  - All three saturate at 0xFFFFFFFF and are unaffected by flush_all.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then lookup_pc=0x40 -> predict_taken=0, predict_target=0x44.
- update_en, update_pc=0x40, taken=1, target=0x100, pred_taken=0 -> mispredict=1, redirect_pc=0x100. Next cycle lookup 0x40 -> predict_taken=1, predict_target=0x100.
- Counter saturation at 0x40:
  - Two not-taken updates -> ctr 01 then 00; lookup gives predict_taken=0, target 0x44.
  - A third not-taken update -> ctr stays 00.
  - Four taken updates -> ctr 11.
  - One not-taken update -> ctr 10, still predicts taken.
- Aliasing, ENTRIES=16: update 0x440 taken target 0x200 (same index as 0x40) -> lookup 0x40 misses (taken=0, 0x44); lookup 0x440 -> taken, 0x200.
- flush_all=1 with update_en=1 (pc=0x80, taken) -> next cycle lookups of 0x40 and 0x80 both miss. A later taken update of 0x40 allocates with ctr=10.
- nRST pulsed between edges after training 0x40 -> predict_taken drops to 0 the same cycle, before any edge. After release, 0x40 misses. With BTB_STATS_EN, all stat counters read 0.

Source files
------------

// File: rtl/btb_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters for fetch-stage next-PC prediction.
// Optional BTB_STATS_EN adds saturating lookup/hit/mispredict statistics outputs.

module btb_entry #(
   parameter int          TAG_W    = 26,
   parameter int          TGT_W    = 30,
   parameter logic [1:0]  CTR_INIT = 2'b01
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             sel,
   input  logic             hit,
   input  logic             taken,
   input  logic [TAG_W-1:0] tag_in,
   input  logic [TGT_W-1:0] tgt_in,
   output logic             valid,
   output logic [TAG_W-1:0] tag,
   output logic [TGT_W-1:0] tgt,
   output logic             dir
);
   logic [1:0] ctr;

   assign dir = ctr[1];

   // Flush clears only the valid bit; counters and targets survive it.
   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         valid <= 1'b0;
         tag   <= '0;
         tgt   <= '0;
         ctr   <= CTR_INIT;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (sel) begin
         if (hit) begin
            if (taken) begin
               tgt <= tgt_in;
               if (ctr != 2'b11) ctr <= ctr + 2'b01;
            end else if (ctr != 2'b00) begin
               ctr <= ctr - 2'b01;
            end
         end else if (taken) begin
            valid <= 1'b1;
            tag   <= tag_in;
            tgt   <= tgt_in;
            ctr   <= 2'b10;
         end
      end
   end
endmodule

module btb_branch_predictor #(
   parameter int         ENTRIES  = 16,
   parameter int         ADDR_W   = 32,
   parameter logic [1:0] CTR_INIT = 2'b01
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              predict_taken,
   output logic [ADDR_W-1:0] predict_target,
   input  logic              update_en,
   input  logic [ADDR_W-1:0] update_pc,
   input  logic              update_taken,
   input  logic [ADDR_W-1:0] update_target,
   input  logic              update_pred_taken,
   input  logic [ADDR_W-1:0] update_pred_target,
   input  logic              flush_all,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc
`ifdef BTB_STATS_EN
   ,
   output logic [31:0]       stat_lookups,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_mispredicts
`endif
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam int TGT_W = ADDR_W - 2;

   logic [ENTRIES-1:0]            e_valid;
   logic [ENTRIES-1:0]            e_dir;
   logic [ENTRIES-1:0][TAG_W-1:0] e_tag;
   logic [ENTRIES-1:0][TGT_W-1:0] e_tgt;

   logic [IDX_W-1:0] lidx, uidx;
   logic [TAG_W-1:0] ltag, utag;
   logic             l_hit, u_hit;

   assign lidx  = lookup_pc[IDX_W+1:2];
   assign ltag  = lookup_pc[ADDR_W-1:IDX_W+2];
   assign uidx  = update_pc[IDX_W+1:2];
   assign utag  = update_pc[ADDR_W-1:IDX_W+2];
   assign l_hit = e_valid[lidx] && (e_tag[lidx] == ltag);
   assign u_hit = e_valid[uidx] && (e_tag[uidx] == utag);

   genvar i;
   generate
      for (i = 0; i < ENTRIES; i++) begin : g_ent
         btb_entry #(.TAG_W(TAG_W), .TGT_W(TGT_W), .CTR_INIT(CTR_INIT)) u_ent (
            .CLK    (CLK),
            .nRST   (nRST),
            .flush  (flush_all),
            .sel    (update_en && (uidx == IDX_W'(i))),
            .hit    (u_hit),
            .taken  (update_taken),
            .tag_in (utag),
            .tgt_in (update_target[ADDR_W-1:2]),
            .valid  (e_valid[i]),
            .tag    (e_tag[i]),
            .tgt    (e_tgt[i]),
            .dir    (e_dir[i])
         );
      end
   endgenerate

   // Lookup sees pre-edge table contents; no bypass from a concurrent update.
   assign predict_taken  = l_hit && e_dir[lidx];
   assign predict_target = predict_taken ? {e_tgt[lidx], 2'b00} : lookup_pc + ADDR_W'(4);

   assign mispredict  = update_en && ((update_taken != update_pred_taken) ||
                        (update_taken && update_pred_taken && (update_target != update_pred_target)));
   assign redirect_pc = !update_en   ? '0 :
                        update_taken ? update_target : update_pc + ADDR_W'(4);

`ifdef BTB_STATS_EN
   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         stat_lookups     <= '0;
         stat_hits        <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (stat_lookups != 32'hFFFF_FFFF) stat_lookups <= stat_lookups + 32'd1;
         if (l_hit && stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
         if (mispredict && stat_mispredicts != 32'hFFFF_FFFF)
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_btb_branch_predictor.sv
// Bench for btb_branch_predictor: table-of-PCs reference model, directed pins plus random traffic.
// Build with BTB_STATS_EN defined to also check the statistics outputs.

module tb_btb_branch_predictor;
   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic [31:0] lookup_pc, update_pc, update_target, update_pred_target;
   logic        update_en, update_taken, update_pred_taken, flush_all;
   logic        predict_taken, mispredict;
   logic [31:0] predict_target, redirect_pc;
`ifdef BTB_STATS_EN
   logic [31:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

   btb_branch_predictor dut (
      .CLK                (CLK),
      .nRST               (nRST),
      .lookup_pc          (lookup_pc),
      .predict_taken      (predict_taken),
      .predict_target     (predict_target),
      .update_en          (update_en),
      .update_pc          (update_pc),
      .update_taken       (update_taken),
      .update_target      (update_target),
      .update_pred_taken  (update_pred_taken),
      .update_pred_target (update_pred_target),
      .flush_all          (flush_all),
      .mispredict         (mispredict),
      .redirect_pc        (redirect_pc)
`ifdef BTB_STATS_EN
      ,
      .stat_lookups       (stat_lookups),
      .stat_hits          (stat_hits),
      .stat_mispredicts   (stat_mispredicts)
`endif
   );

   always #5 CLK = ~CLK;

   // Reference model: each of the 16 slots remembers the full PC that owns it.
   bit          m_valid [16];
   logic [31:0] m_pc    [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   int unsigned m_lk, m_hits, m_mis;

   int vectors = 0, miscompares = 0;
   bit chk_en = 1'b0;
   bit pin_lk = 1'b0, pin_up = 1'b0;
   logic        pin_taken, pin_mis;
   logic [31:0] pin_tgt, pin_red;

   function automatic bit lk_hit(input logic [31:0] pc);
      return m_valid[pc[5:2]] && ((m_pc[pc[5:2]] >> 6) == (pc >> 6));
   endfunction

   function automatic logic m_pred_taken(input logic [31:0] pc);
      return lk_hit(pc) && (m_ctr[pc[5:2]] >= 2);
   endfunction

   function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
      return m_pred_taken(pc) ? m_tgt[pc[5:2]] : pc + 32'd4;
   endfunction

   function automatic logic exp_mis();
      return update_en && ((update_taken != update_pred_taken) ||
             (update_taken && update_pred_taken && update_target != update_pred_target));
   endfunction

   function automatic logic [31:0] exp_red();
      if (!update_en) return 32'h0;
      return update_taken ? update_target : update_pc + 32'd4;
   endfunction

   always @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         for (int i = 0; i < 16; i++) begin
            m_valid[i] <= 1'b0;
            m_pc[i]    <= 32'h0;
            m_tgt[i]   <= 32'h0;
            m_ctr[i]   <= 1;
         end
         m_lk   <= 0;
         m_hits <= 0;
         m_mis  <= 0;
      end else begin
         m_lk   <= m_lk + 1;
         m_hits <= m_hits + (lk_hit(lookup_pc) ? 1 : 0);
         m_mis  <= m_mis + (exp_mis() ? 1 : 0);
         if (flush_all) begin
            for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
         end else if (update_en) begin
            if (lk_hit(update_pc)) begin
               if (update_taken) begin
                  m_ctr[update_pc[5:2]] <= (m_ctr[update_pc[5:2]] == 3) ? 3 : m_ctr[update_pc[5:2]] + 1;
                  m_tgt[update_pc[5:2]] <= update_target & ~32'h3;
               end else begin
                  m_ctr[update_pc[5:2]] <= (m_ctr[update_pc[5:2]] == 0) ? 0 : m_ctr[update_pc[5:2]] - 1;
               end
            end else if (update_taken) begin
               m_valid[update_pc[5:2]] <= 1'b1;
               m_pc[update_pc[5:2]]    <= update_pc;
               m_tgt[update_pc[5:2]]   <= update_target & ~32'h3;
               m_ctr[update_pc[5:2]]   <= 2;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("predict_taken",  {31'b0, predict_taken}, {31'b0, m_pred_taken(lookup_pc)});
         chk("predict_target", predict_target, m_pred_tgt(lookup_pc));
         chk("mispredict",     {31'b0, mispredict}, {31'b0, exp_mis()});
         chk("redirect_pc",    redirect_pc, exp_red());
         if (pin_lk) begin
            chk("pin_taken",  {31'b0, predict_taken}, {31'b0, pin_taken});
            chk("pin_target", predict_target, pin_tgt);
         end
         if (pin_up) begin
            chk("pin_mispredict", {31'b0, mispredict}, {31'b0, pin_mis});
            chk("pin_redirect",   redirect_pc, pin_red);
         end
`ifdef BTB_STATS_EN
         chk("stat_lookups",     stat_lookups, m_lk);
         chk("stat_hits",        stat_hits, m_hits);
         chk("stat_mispredicts", stat_mispredicts, m_mis);
`endif
      end
   end

   task automatic pin_l(input logic t, input logic [31:0] tg);
      pin_lk = 1'b1; pin_taken = t; pin_tgt = tg;
   endtask

   task automatic pin_u(input logic m, input logic [31:0] r);
      pin_up = 1'b1; pin_mis = m; pin_red = r;
   endtask

   // Called just after a rising edge; applies inputs for one full cycle.
   task automatic drv(input logic [31:0] lk, input logic ue, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg, input logic upt,
                      input logic [31:0] uptg, input logic fl);
      lookup_pc = lk; update_en = ue; update_pc = upc; update_taken = ut;
      update_target = utg; update_pred_taken = upt; update_pred_target = uptg; flush_all = fl;
      @(posedge CLK); #1;
      pin_lk = 1'b0; pin_up = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc);
      drv(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) pc = pc | 32'hFFFF_FF00;
      return pc;
   endfunction

   logic [31:0] r_lk, r_upc, r_tgt, r_ptgt;
   logic        r_ue, r_ut, r_pt, r_fl;

   initial begin
      lookup_pc = 32'h40; update_en = 1'b0; update_pc = 32'h0; update_taken = 1'b0;
      update_target = 32'h0; update_pred_taken = 1'b0; update_pred_target = 32'h0; flush_all = 1'b0;
      #1 nRST = 1'b1;
      chk_en = 1'b1;
      pin_l(1'b0, 32'h44);
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b0;
      pin_lk = 1'b0;

      pin_l(1'b0, 32'h44); look(32'h40);
      pin_l(1'b0, 32'h44); pin_u(1'b1, 32'h100);
      drv(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      pin_l(1'b1, 32'h100); look(32'h40);

      // Counter walk at 0x40: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01
      pin_u(1'b1, 32'h44);
      drv(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      pin_l(1'b0, 32'h44);
      drv(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      drv(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      pin_l(1'b0, 32'h44);
      drv(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      pin_l(1'b0, 32'h44);
      drv(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      pin_l(1'b1, 32'h100);
      drv(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
      pin_l(1'b1, 32'h100);
      drv(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
      drv(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      pin_l(1'b1, 32'h100); look(32'h40);
      drv(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      pin_l(1'b0, 32'h44); look(32'h40);

      // Aliasing on index 0
      pin_u(1'b1, 32'h200);
      drv(32'h40, 1'b1, 32'h440, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
      pin_l(1'b0, 32'h44); look(32'h40);
      pin_l(1'b1, 32'h200); look(32'h440);

      // Flush beats a concurrent update
      pin_l(1'b1, 32'h200); pin_u(1'b1, 32'h300);
      drv(32'h440, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
      pin_l(1'b0, 32'h444); look(32'h440);
      pin_l(1'b0, 32'h84);  look(32'h80);
      pin_l(1'b0, 32'h44);  look(32'h40);
      drv(32'h40, 1'b1, 32'h40, 1'b1, 32'h340, 1'b0, 32'h0, 1'b0);
      pin_l(1'b1, 32'h340); look(32'h40);
      drv(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h340, 1'b0);
      pin_l(1'b0, 32'h44); look(32'h40);

      pin_l(1'b0, 32'h0); look(32'hFFFF_FFFC);
      pin_u(1'b0, 32'h0);
      drv(32'h40, 1'b0, 32'h40, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);

      for (int n = 0; n < 800; n++) begin
         r_lk  = rand_pc();
         r_upc = rand_pc();
         r_ue  = ($urandom_range(0, 9) < 6);
         r_ut  = 1'($urandom_range(0, 1));
         r_tgt = ($urandom_range(0, 1) == 1) ? m_tgt[r_upc[5:2]] : ($urandom & 32'hFFFF_FFFC);
         if ($urandom_range(0, 7) == 0) r_tgt = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            r_pt   = m_pred_taken(r_upc);
            r_ptgt = m_pred_tgt(r_upc);
         end else begin
            r_pt   = 1'($urandom_range(0, 1));
            r_ptgt = $urandom;
         end
         r_fl = ($urandom_range(0, 49) == 0);
         drv(r_lk, r_ue, r_upc, r_ut, r_tgt, r_pt, r_ptgt, r_fl);
      end

      // Asynchronous reset between edges
      repeat (3) drv(32'h40, 1'b1, 32'h40, 1'b1, 32'h120, 1'b1, 32'h120, 1'b0);
      pin_l(1'b1, 32'h120); look(32'h40);
      lookup_pc = 32'h40; update_en = 1'b0; flush_all = 1'b0;
      pin_l(1'b0, 32'h44);
      #1 nRST = 1'b1;
      @(negedge CLK); #2 nRST = 1'b0;
      @(posedge CLK); #1;
      pin_lk = 1'b0;
      pin_l(1'b0, 32'h44); look(32'h40);
      look(32'h80);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
